multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the 16-bit CPU; the producer side of the ALU opcode interface.
- Sequences fetch/decode/execute/memory/writeback for each instruction.
- Drives alu_op[3:0], datapath enables and a req/ready memory handshake; consumes the instruction word and the ALU zero flag.
- Sits between the instruction register/memory port and the datapath (regfile, ALU, PC).

Parameters:
- TIMEOUT, 255, max cycles mem_req may wait for mem_ready before error halt (1..255, 8-bit counter).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- instr  input  16  IR contents; [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm4
- alu_zero  input  1  ALU zero flag, valid in EXEC
- mem_ready  input  1  memory completes current request this cycle
- alu_op  output  4  opcode to ALU
- alu_src_imm  output  1  ALU b = sign-extended imm4 (addi/ldr/str)
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  write request (str); 0 = read
- mem_addr_sel  output  1  0 = PC (fetch), 1 = ALU result
- ir_write  output  1  load IR from memory data
- pc_write  output  1  update PC
- pc_src  output  1  0 = PC+1, 1 = branch target (PC + sign-extended instr[7:0])
- reg_write  output  1  write regfile[rd]
- wb_sel_mem  output  1  writeback data: 1 = memory, 0 = ALU
- halted  output  1  sticky halt
- err_timeout  output  1  sticky, halt caused by memory timeout

Behaviour:
- Moore FSM; all outputs decode from the registered state plus instr[15:12]. Opcodes: add 0, addi 1, sub 2, and 3, or 4, xor 5, not 6, slt 7, lsl 8, lsr 9, ldr A, str B, beq C, b D, nop E, halt F.
- Reset (rst_n low at edge): state <= RST, counter <= 0, halted/err_timeout <= 0. In RST every output is 0. RST -> FETCH unconditionally on the next edge.
- FETCH:
  - Asserts mem_req=1, mem_we=0, mem_addr_sel=0.
  - When mem_ready: ir_write=1, pc_write=1, pc_src=0 in that same cycle; -> DECODE.
- DECODE: 1 cycle, no outputs; regfile read. -> EXEC.
- EXEC: alu_op=opcode for opcodes 0..C; alu_src_imm=1 for 1/A/B. Next state by opcode:
  - 0..9 -> WB.
  - A/B -> MEM.
  - C (beq): pc_write = alu_zero, pc_src=1; -> FETCH.
  - D (b): pc_write=1, pc_src=1; -> FETCH.
  - E (nop): -> FETCH.
  - F (halt): -> HALT.
- MEM:
  - Holds alu_op and alu_src_imm from EXEC so the address stays stable.
  - Asserts mem_req=1, mem_addr_sel=1, mem_we=(opcode==B).
  - On mem_ready: ldr -> WB; str -> FETCH.
- WB: reg_write=1 for one cycle, wb_sel_mem=(opcode==A); alu_op held at opcode for ALU ops. -> FETCH.
- HALT: halted=1; all other outputs 0; sticky until reset.
- Handshake rules:
  - mem_req, mem_we and mem_addr_sel stay constant from first assertion until the mem_ready cycle inclusive.
  - mem_req deasserts the cycle after mem_ready.
  - mem_ready outside FETCH/MEM is ignored.
- Timeout:
  - 8-bit wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 && !mem_ready.
  - When the counter reaches TIMEOUT without mem_ready: -> HALT with err_timeout=1.
  - mem_ready in the same cycle the count hits TIMEOUT wins (normal completion).
- Instruction latency: ALU op 4 cycles (fetch ready in 1), ldr 5, str 4, beq/b/nop 3, plus memory wait cycles.
- Reset mid-transaction: next edge -> RST; mem_req low from that cycle; no pc_write, reg_write or ir_write is issued.
- instr is sampled only in DECODE..WB (IR stable); the FSM never writes IR outside FETCH.

Decomposition:
- Shared package (existing macro_defines.v): opcode macros, state encoding macros (RST, FETCH, DECODE, EXEC, MEM, WB, HALT, 3-bit), and field-slice macros for instr.
- One natural sub-module: mem_wait_timer (counter plus TIMEOUT compare, clear/enable inputs, expired output). Next-state logic and output decode stay in multicycle_control.

Test Plan:
- Reset then `add` (instr 0x0123), mem_ready on first FETCH cycle:
  - required: RST, then FETCH (ir_write=pc_write=1), DECODE, EXEC (alu_op=0), WB (reg_write=1, wb_sel_mem=0), then FETCH.
- `ldr` (0xA120), mem_ready delayed 3 cycles in MEM:
  - required: mem_req=1, mem_addr_sel=1, mem_we=0, alu_op=A held stable for all 4 MEM cycles.
  - then WB with wb_sel_mem=1, reg_write=1.
- `str` (0xB120): mem_we=1 in MEM; after mem_ready the next state is FETCH; reg_write never asserts.
- `beq` (0xC1F0) twice:
  - alu_zero=1 -> pc_write=1, pc_src=1 in EXEC.
  - alu_zero=0 -> pc_write=0; both cases return to FETCH.
- TIMEOUT=4, mem_ready held 0 in FETCH:
  - required: 4 wait cycles, then HALT with halted=1, err_timeout=1, mem_req=0; stays halted until rst_n=0.
- `halt` (0xF000) reaches HALT; a separate run pulses rst_n low during MEM of `ldr`:
  - required: next cycle all outputs 0 (RST), then FETCH; no reg_write observed.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared types for the multi-cycle CPU controller: FSM state encoding,
// ALU/instruction opcodes and small opcode-class helpers.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_NOT  = 4'h6,
        OP_SLT  = 4'h7,
        OP_LSL  = 4'h8,
        OP_LSR  = 4'h9,
        OP_LDR  = 4'hA,
        OP_STR  = 4'hB,
        OP_BEQ  = 4'hC,
        OP_B    = 4'hD,
        OP_NOP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;

    // Register-to-register and register-immediate ALU instructions (write back ALU result).
    function automatic logic is_alu_op(input opcode_e op);
        return (op <= OP_LSR);
    endfunction

    // Instructions whose ALU b operand is the sign-extended imm4 field.
    function automatic logic uses_imm(input opcode_e op);
        return (op == OP_ADDI) || (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts cycles a memory request waits for mem_ready; flags expiry when the
// current wait would be the TIMEOUT-th one.
module multicycle_control_mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end
    end

    // A cycle with mem_ready never enables the timer, so a late completion always wins.
    assign expired = enable && !clear && (count_q == LAST_WAIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the 16-bit multi-cycle CPU: fetch/decode/execute/
// memory/writeback sequencing, ALU opcode drive and memory req/ready handshake.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        wb_sel_mem,
    output logic        halted,
    output logic        err_timeout
);

    state_e  state_q, state_d;
    logic    err_timeout_q, err_timeout_d;
    opcode_e opcode;
    logic    wait_clear, wait_en, wait_expired;
    logic    unused_instr_fields;

    assign opcode              = opcode_e'(instr[OPCODE_MSB:OPCODE_LSB]);
    assign unused_instr_fields = ^instr[OPCODE_LSB-1:0];

    // Leaving FETCH/MEM only happens on mem_ready or timeout, so clearing on
    // mem_ready and outside those states gives a zero count on every entry.
    assign wait_en    = mem_req && !mem_ready;
    assign wait_clear = mem_ready || !((state_q == ST_FETCH) || (state_q == ST_MEM));

    multicycle_control_mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear),
        .enable  (wait_en),
        .expired (wait_expired)
    );

    always_comb begin
        alu_op       = 4'h0;
        alu_src_imm  = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        reg_write    = 1'b0;
        wb_sel_mem   = 1'b0;
        halted       = 1'b0;
        err_timeout  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            ST_EXEC: begin
                if (opcode <= OP_BEQ) begin
                    alu_op = opcode;
                end
                alu_src_imm = uses_imm(opcode);
                if (opcode == OP_BEQ) begin
                    pc_write = alu_zero;
                    pc_src   = 1'b1;
                end
                if (opcode == OP_B) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
            end
            ST_MEM: begin
                alu_op       = opcode;
                alu_src_imm  = 1'b1;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OP_STR);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                wb_sel_mem = (opcode == OP_LDR);
                // No ALU result register: keep the ALU configured while its output is written back.
                if (is_alu_op(opcode)) begin
                    alu_op      = opcode;
                    alu_src_imm = uses_imm(opcode);
                end
            end
            ST_HALT: begin
                halted      = 1'b1;
                err_timeout = err_timeout_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            ST_RST:    state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d       = ST_HALT;
                    err_timeout_d = 1'b1;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (is_alu_op(opcode)) begin
                    state_d = ST_WB;
                end else begin
                    case (opcode)
                        OP_LDR, OP_STR:      state_d = ST_MEM;
                        OP_BEQ, OP_B, OP_NOP: state_d = ST_FETCH;
                        default:             state_d = ST_HALT;
                    endcase
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (opcode == OP_LDR) ? ST_WB : ST_FETCH;
                end else if (wait_expired) begin
                    state_d       = ST_HALT;
                    err_timeout_d = 1'b1;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RST;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_timeout_q <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected output vectors are
// queued as stimulus is applied and compared when the DUT outputs are sampled.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        alu_zero;
    logic        mem_ready;
    logic [3:0]  alu_op;
    logic        alu_src_imm, mem_req, mem_we, mem_addr_sel, ir_write;
    logic        pc_write, pc_src, reg_write, wb_sel_mem, halted, err_timeout;

    int checks = 0;
    int errors = 0;

    logic [14:0] exp_q[$];
    string       tag_q[$];

    // Output vector layout: {alu_op[3:0], imm, req, we, asel, irw, pcw, psrc, regw, wbm, hlt, err}
    localparam logic [14:0] IMM  = 15'h400;
    localparam logic [14:0] REQ  = 15'h200;
    localparam logic [14:0] WE   = 15'h100;
    localparam logic [14:0] ASEL = 15'h080;
    localparam logic [14:0] IRW  = 15'h040;
    localparam logic [14:0] PCW  = 15'h020;
    localparam logic [14:0] PSRC = 15'h010;
    localparam logic [14:0] REGW = 15'h008;
    localparam logic [14:0] WBM  = 15'h004;
    localparam logic [14:0] HLT  = 15'h002;
    localparam logic [14:0] ERR  = 15'h001;

    multicycle_control #(
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .alu_op       (alu_op),
        .alu_src_imm  (alu_src_imm),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .wb_sel_mem   (wb_sel_mem),
        .halted       (halted),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] op(input logic [3:0] o);
        return {o, 11'b0};
    endfunction

    task automatic check_out();
        logic [14:0] obs;
        logic [14:0] exp;
        string       tag;
        obs = {alu_op, alu_src_imm, mem_req, mem_we, mem_addr_sel, ir_write,
               pc_write, pc_src, reg_write, wb_sel_mem, halted, err_timeout};
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[%0t] %-14s outputs=%h expected=%h", $time, tag, obs, exp);
    endtask

    // One clock of stimulus: drive inputs, queue the expected outputs, sample mid-cycle.
    task automatic cyc(input string tag, input logic rdy, input logic z, input logic [14:0] exp);
        mem_ready = rdy;
        alu_zero  = z;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        instr     = 16'h0000;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rst_state", 1'b1, 1'b0, 15'h0);

        // add: 4 cycles with memory ready on the first fetch cycle
        instr = 16'h0123;
        cyc("add_fetch",  1'b1, 1'b0, REQ | IRW | PCW);
        cyc("add_decode", 1'b0, 1'b0, 15'h0);
        cyc("add_exec",   1'b0, 1'b0, op(4'h0));
        cyc("add_wb",     1'b0, 1'b0, op(4'h0) | REGW);

        // sub, with mem_ready wiggling in DECODE where it must be ignored
        instr = 16'h2345;
        cyc("sub_fetch",  1'b1, 1'b0, REQ | IRW | PCW);
        cyc("sub_decode", 1'b1, 1'b0, 15'h0);
        cyc("sub_exec",   1'b1, 1'b0, op(4'h2));
        cyc("sub_wb",     1'b1, 1'b0, op(4'h2) | REGW);

        // ldr with 3 wait cycles in MEM
        instr = 16'hA120;
        cyc("ldr_fetch",  1'b1, 1'b0, REQ | IRW | PCW);
        cyc("ldr_decode", 1'b0, 1'b0, 15'h0);
        cyc("ldr_exec",   1'b0, 1'b0, op(4'hA) | IMM);
        cyc("ldr_mem_w1", 1'b0, 1'b0, op(4'hA) | IMM | REQ | ASEL);
        cyc("ldr_mem_w2", 1'b0, 1'b0, op(4'hA) | IMM | REQ | ASEL);
        cyc("ldr_mem_w3", 1'b0, 1'b0, op(4'hA) | IMM | REQ | ASEL);
        cyc("ldr_mem_rdy", 1'b1, 1'b0, op(4'hA) | IMM | REQ | ASEL);
        cyc("ldr_wb",     1'b0, 1'b0, REGW | WBM);

        // str: one wait then completion, straight back to FETCH
        instr = 16'hB120;
        cyc("str_fetch",  1'b1, 1'b0, REQ | IRW | PCW);
        cyc("str_decode", 1'b0, 1'b0, 15'h0);
        cyc("str_exec",   1'b0, 1'b0, op(4'hB) | IMM);
        cyc("str_mem_w1", 1'b0, 1'b0, op(4'hB) | IMM | REQ | WE | ASEL);
        cyc("str_mem_rdy", 1'b1, 1'b0, op(4'hB) | IMM | REQ | WE | ASEL);

        // beq taken then not taken
        instr = 16'hC1F0;
        cyc("beq1_fetch", 1'b1, 1'b0, REQ | IRW | PCW);
        cyc("beq1_decode", 1'b0, 1'b0, 15'h0);
        cyc("beq1_exec",  1'b0, 1'b1, op(4'hC) | PCW | PSRC);
        cyc("beq0_fetch", 1'b1, 1'b0, REQ | IRW | PCW);
        cyc("beq0_decode", 1'b0, 1'b0, 15'h0);
        cyc("beq0_exec",  1'b0, 1'b0, op(4'hC) | PSRC);

        // unconditional branch and nop
        instr = 16'hD005;
        cyc("b_fetch",    1'b1, 1'b0, REQ | IRW | PCW);
        cyc("b_decode",   1'b0, 1'b0, 15'h0);
        cyc("b_exec",     1'b0, 1'b0, PCW | PSRC);
        instr = 16'hE000;
        cyc("nop_fetch",  1'b1, 1'b0, REQ | IRW | PCW);
        cyc("nop_decode", 1'b0, 1'b0, 15'h0);
        cyc("nop_exec",   1'b0, 1'b1, 15'h0);

        // halt instruction: sticky until reset
        instr = 16'hF000;
        cyc("halt_fetch", 1'b1, 1'b0, REQ | IRW | PCW);
        cyc("halt_decode", 1'b0, 1'b0, 15'h0);
        cyc("halt_exec",  1'b0, 1'b0, 15'h0);
        cyc("halt_st1",   1'b1, 1'b0, HLT);
        cyc("halt_st2",   1'b0, 1'b0, HLT);
        rst_n = 1'b0;
        cyc("halt_rst_in", 1'b0, 1'b0, HLT);
        rst_n = 1'b1;
        cyc("halt_rst_st", 1'b0, 1'b0, 15'h0);

        // reset pulse during MEM of ldr: no writeback may follow
        instr = 16'hA120;
        cyc("ldrr_fetch", 1'b1, 1'b0, REQ | IRW | PCW);
        cyc("ldrr_decode", 1'b0, 1'b0, 15'h0);
        cyc("ldrr_exec",  1'b0, 1'b0, op(4'hA) | IMM);
        rst_n = 1'b0;
        cyc("ldrr_mem",   1'b0, 1'b0, op(4'hA) | IMM | REQ | ASEL);
        rst_n = 1'b1;
        cyc("ldrr_rst_st", 1'b1, 1'b0, 15'h0);

        // fetch timeout: 4 unanswered wait cycles then error halt
        cyc("to_fetch_w1", 1'b0, 1'b0, REQ);
        cyc("to_fetch_w2", 1'b0, 1'b0, REQ);
        cyc("to_fetch_w3", 1'b0, 1'b0, REQ);
        cyc("to_fetch_w4", 1'b0, 1'b0, REQ);
        cyc("to_halt1",   1'b1, 1'b0, HLT | ERR);
        cyc("to_halt2",   1'b0, 1'b0, HLT | ERR);
        rst_n = 1'b0;
        cyc("to_rst_in",  1'b0, 1'b0, HLT | ERR);
        rst_n = 1'b1;
        cyc("to_rst_st",  1'b0, 1'b0, 15'h0);

        // mem_ready arriving on the last allowed wait cycle completes normally
        instr = 16'hE000;
        cyc("edge_w1",    1'b0, 1'b0, REQ);
        cyc("edge_w2",    1'b0, 1'b0, REQ);
        cyc("edge_w3",    1'b0, 1'b0, REQ);
        cyc("edge_rdy",   1'b1, 1'b0, REQ | IRW | PCW);
        cyc("edge_decode", 1'b0, 1'b0, 15'h0);
        cyc("edge_exec",  1'b0, 1'b0, 15'h0);
        cyc("edge_fetch", 1'b1, 1'b0, REQ | IRW | PCW);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
